pll_reset_sync: RTL and testbench
=================================

Name: pll_reset_sync

Overview:
- Consumer end of the PLL interface. Runs in the PLL output clock domain and takes the PLL `locked` flag, which is asynchronous to this domain.
- Qualifies lock, then generates a clean, held, synchronously released system reset for downstream logic.
- Detects loss of lock during operation and counts such events.
- Sits directly after every PLL instance, between the PLL and the first user logic in the derived clock domain.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before lock is qualified; minimum 1
RESET_HOLD_CYCLES, 16, cycles `sys_reset` stays asserted after lock qualifies; minimum 1
CNT_W, 16, width of the internal qualify/hold counter; must hold max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)-1

Ports:
clock_in  input  1  PLL output clock; the only clock
reset  input  1  asynchronous, active-high reset
locked  input  1  PLL lock flag; asynchronous to clock_in
clear_count  input  1  synchronous; zeroes loss_count
sys_reset  output  1  active-high reset for the downstream domain
ready  output  1  high while the domain is running on a qualified clock
lock_lost  output  1  one-cycle pulse on each loss of lock while in RUN
loss_count  output  8  saturating count of lock_lost events

Behaviour:
- Interface (already decided): one clock, clock_in; reset is asynchronous and active-high, named reset.
- `locked` passes through a 2-flop synchronizer; its output is locked_s. Both sync flops reset to 0.
- Reset values: state=WAIT_LOCK, sys_reset=1, ready=0, lock_lost=0, loss_count=0, cnt=0. Reset asserted mid-operation forces these immediately (asynchronous). Reset release needs no special handling beyond normal state sequencing.
- States:
  - WAIT_LOCK: if locked_s=1, go to STABLE with cnt=0.
  - STABLE: if locked_s=0, go to WAIT_LOCK. Else if cnt=LOCK_STABLE_CYCLES-1, go to HOLD with cnt=0. Else cnt+1.
  - HOLD: if locked_s=0, go to WAIT_LOCK; this is not counted as a loss. Else if cnt=RESET_HOLD_CYCLES-1, go to RUN. Else cnt+1.
  - RUN: if locked_s=0, go to WAIT_LOCK; assert lock_lost for one cycle; loss_count+1.
- Outputs:
  - sys_reset=1 in every state except RUN.
  - ready=1 only in RUN.
  - Both are registered; no combinational path from `locked`.
- Latency:
  - `locked` rise sampled at edge 0 → RUN entered at edge 2+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
  - `locked` fall sampled at edge n while in RUN → sys_reset=1, ready=0, lock_lost=1 after edge n+2.
- Glitches: any locked_s drop in STABLE or HOLD restarts qualification from WAIT_LOCK, with cnt reloaded on re-entry.
- loss_count:
  - Saturates at 255; no wrap.
  - clear_count=1 zeroes it at the next edge.
  - clear_count coincident with a loss event: clear wins, count=0. lock_lost still pulses.
- Lock chatter: a loss in RUN immediately followed by re-lock needs the full qualify and hold sequence again.

Optional Feature:
- Macro: PLL_RESET_SYNC_LOSS_COUNT_EN.
- Defined: lock_lost and loss_count behave as above.
- Undefined:
  - lock_lost and loss_count are tied to 0; the count register and clear logic are not built.
  - clear_count is ignored.
  - State machine, sys_reset and ready are unchanged.

Test Plan:
- Params L=4, H=3; reset, then locked=1 sampled at edge 0 → sys_reset=1 and ready=0 through edge 8; sys_reset=0 and ready=1 after edge 9.
- locked pulses high for 2 cycles, then low, during qualification → returns to WAIT_LOCK, never reaches RUN, loss_count stays 0, no lock_lost pulse.
- In RUN, locked drops at edge n → after edge n+2: sys_reset=1, ready=0, lock_lost=1 for exactly one cycle, loss_count=1. Re-lock → RUN again 2+4+3 edges after re-lock sampling.
- 260 loss/re-lock cycles → loss_count saturates at 255. Then clear_count=1 coincident with a loss → loss_count=0 and lock_lost=1.
- reset asserted asynchronously mid-HOLD and mid-RUN → sys_reset=1, ready=0, loss_count=0 immediately, without waiting for a clock edge. Release with locked=1 → full qualify and hold sequence.
- Build without PLL_RESET_SYNC_LOSS_COUNT_EN, repeat the loss scenario → lock_lost=0 and loss_count=0 always; sys_reset/ready timing identical to the macro-defined build.

Source files
------------

// File: rtl/pll_reset_sync.sv
// ---------------------------------------------------------------------------
// pll_reset_sync
//
// Consumer end of a PLL. Runs in the PLL output clock domain, qualifies the
// asynchronous PLL lock flag, and produces a clean, held, synchronously
// released reset for the logic that follows. Loss of lock while the domain is
// running is flagged and counted.
//
// Optional feature macro: PLL_RESET_SYNC_LOSS_COUNT_EN
//   defined   : lock_lost pulses on each loss of lock in RUN, and loss_count
//               keeps a saturating tally that clear_count zeroes.
//   undefined : lock_lost and loss_count are tied to 0 and clear_count is
//               ignored. The state machine, sys_reset and ready are unchanged.
//
// Parameters
//   LOCK_STABLE_CYCLES : consecutive synchronized-lock cycles needed (>= 1)
//   RESET_HOLD_CYCLES  : cycles sys_reset stays high after qualification (>= 1)
//   CNT_W              : qualify/hold counter width
//
// Ports
//   clock_in    in   PLL output clock, the only clock
//   reset       in   asynchronous, active-high reset
//   locked      in   PLL lock flag, asynchronous to clock_in
//   clear_count in   synchronous clear of loss_count
//   sys_reset   out  active-high reset for the downstream domain (registered)
//   ready       out  high while running on a qualified clock (registered)
//   lock_lost   out  one-cycle pulse on each loss of lock in RUN
//   loss_count  out  8-bit saturating count of lock_lost events
// ---------------------------------------------------------------------------
module pll_reset_sync #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_W              = 16
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    input  logic       clear_count,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             r_syncMeta;
    logic             r_syncOut;
    logic             w_lockedS;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sysReset;
    logic             r_ready;
    logic             w_lossEvent;

    // Two-flop synchronizer for the asynchronous lock flag; only r_syncOut
    // may be used by the rest of the design.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_syncMeta <= 1'b0;
            r_syncOut  <= 1'b0;
        end else begin
            r_syncMeta <= locked;
            r_syncOut  <= r_syncMeta;
        end
    end

    assign w_lockedS = r_syncOut;

    // A drop of the synchronized lock while running is the only event that
    // counts as a loss; drops during qualification just restart it.
    assign w_lossEvent = (r_state == RUN) && !w_lockedS;

    // Lock qualification state machine. sys_reset and ready are registered
    // from the next state so they change on the same edge the state does.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_sysReset <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lockedS) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end
                    r_sysReset <= 1'b1;
                    r_ready    <= 1'b0;
                end
                STABLE: begin
                    if (!w_lockedS) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_sysReset <= 1'b1;
                    r_ready    <= 1'b0;
                end
                HOLD: begin
                    if (!w_lockedS) begin
                        r_state    <= WAIT_LOCK;
                        r_sysReset <= 1'b1;
                        r_ready    <= 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state    <= RUN;
                        r_sysReset <= 1'b0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_sysReset <= 1'b1;
                        r_ready    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!w_lockedS) begin
                        r_state    <= WAIT_LOCK;
                        r_sysReset <= 1'b1;
                        r_ready    <= 1'b0;
                    end else begin
                        r_sysReset <= 1'b0;
                        r_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= WAIT_LOCK;
                    r_cnt      <= '0;
                    r_sysReset <= 1'b1;
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    assign sys_reset = r_sysReset;
    assign ready     = r_ready;

`ifdef PLL_RESET_SYNC_LOSS_COUNT_EN
    logic       r_lockLost;
    logic [7:0] r_lossCount;

    // Loss pulse and saturating tally. A clear on the same edge as a loss
    // wins for the count, but the pulse is still produced.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_lockLost  <= 1'b0;
            r_lossCount <= 8'd0;
        end else begin
            r_lockLost <= w_lossEvent;
            if (clear_count) begin
                r_lossCount <= 8'd0;
            end else if (w_lossEvent && (r_lossCount != 8'hFF)) begin
                r_lossCount <= r_lossCount + 8'd1;
            end
        end
    end

    assign lock_lost  = r_lockLost;
    assign loss_count = r_lossCount;
`else
    logic w_unusedLossInputs;

    // Without the counter there is nothing to consume the clear or the
    // loss event; they are gathered here so the intent is explicit.
    assign w_unusedLossInputs = clear_count ^ w_lossEvent;
    assign lock_lost          = 1'b0;
    assign loss_count         = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sync.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sync
//
// Self-checking bench for pll_reset_sync with LOCK_STABLE_CYCLES=4 and
// RESET_HOLD_CYCLES=3. The reference model tracks the run length of
// consecutive synchronized-lock samples: the domain is running once that
// run reaches 1+L+H samples, and a zero sample while running is a loss.
// Honors PLL_RESET_SYNC_LOSS_COUNT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_pll_reset_sync;

    localparam int L      = 4;
    localparam int H      = 3;
    localparam int RUN_AT = 1 + L + H;
`ifdef PLL_RESET_SYNC_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clock_in    = 1'b0;
    logic       reset       = 1'b1;
    logic       locked      = 1'b0;
    logic       clear_count = 1'b0;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;

    int vectors     = 0;
    int miscompares = 0;
    bit compareOn   = 1'b0;

    // Reference model state
    bit mSync1   = 1'b0;
    bit mSync2   = 1'b0;
    int mRunLen  = 0;
    bit mSys     = 1'b1;
    bit mReady   = 1'b0;
    bit mLost    = 1'b0;
    int mCount   = 0;

    pll_reset_sync #(
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (H),
        .CNT_W             (16)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .locked     (locked),
        .clear_count(clear_count),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clock_in = ~clock_in;

    // Behavioural model: run-length of synchronized-lock samples decides
    // whether the domain runs; a zero sample after a full run is a loss.
    always @(posedge clock_in or posedge reset) begin
        bit lockedS;
        bit wasRun;
        bit lost;
        if (reset) begin
            mSync1  = 1'b0;
            mSync2  = 1'b0;
            mRunLen = 0;
            mSys    = 1'b1;
            mReady  = 1'b0;
            mLost   = 1'b0;
            mCount  = 0;
        end else begin
            lockedS = mSync2;
            wasRun  = (mRunLen >= RUN_AT);
            lost    = wasRun && !lockedS;
            if (lockedS) mRunLen = (mRunLen >= RUN_AT) ? RUN_AT : mRunLen + 1;
            else         mRunLen = 0;
            mReady = (mRunLen >= RUN_AT);
            mSys   = !mReady;
            if (CNT_EN) begin
                mLost = lost;
                if (clear_count)              mCount = 0;
                else if (lost && mCount < 255) mCount = mCount + 1;
            end else begin
                mLost  = 1'b0;
                mCount = 0;
            end
            mSync2 = mSync1;
            mSync1 = locked;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit lockedVal, input bit clearVal);
        @(negedge clock_in);
        locked      = lockedVal;
        clear_count = clearVal;
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clock_in) begin
        if (compareOn) begin
            checkOutput("model_sys_reset",  int'(sys_reset),  int'(mSys));
            checkOutput("model_ready",      int'(ready),      int'(mReady));
            checkOutput("model_lock_lost",  int'(lock_lost),  int'(mLost));
            checkOutput("model_loss_count", int'(loss_count), mCount);
        end
    end

    // Expects locked=1 to have just been driven before edge 0; checks the
    // release lands exactly on edge 2+L+H.
    task automatic runQualify(input string tag);
        for (int k = 0; k <= 2 + L + H; k++) begin
            @(posedge clock_in);
            #1;
            checkOutput($sformatf("%s_ready_e%0d", tag, k), int'(ready), (k >= 2 + L + H) ? 1 : 0);
            checkOutput($sformatf("%s_sysrst_e%0d", tag, k), int'(sys_reset), (k >= 2 + L + H) ? 0 : 1);
        end
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clock_in);
        #1;
        compareOn = 1'b1;
        @(negedge clock_in);
        reset = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_sys_reset",  int'(sys_reset),  1);
        checkOutput("rst_ready",      int'(ready),      0);
        checkOutput("rst_lock_lost",  int'(lock_lost),  0);
        checkOutput("rst_loss_count", int'(loss_count), 0);

        // Short lock glitch during qualification never reaches RUN
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(posedge clock_in);
            #1;
            checkOutput("glitch_ready", int'(ready), 0);
            checkOutput("glitch_lock_lost", int'(lock_lost), 0);
            checkOutput("glitch_loss_count", int'(loss_count), 0);
        end

        // Full qualification latency
        applyStimulus(1'b1, 1'b0);
        runQualify("first");

        // Loss in RUN: visible after edge n+2, pulse lasts one cycle
        applyStimulus(1'b0, 1'b0);
        @(posedge clock_in); #1;
        checkOutput("loss_n_ready", int'(ready), 1);
        @(posedge clock_in); #1;
        checkOutput("loss_n1_ready", int'(ready), 1);
        @(posedge clock_in); #1;
        checkOutput("loss_n2_ready", int'(ready), 0);
        checkOutput("loss_n2_sys_reset", int'(sys_reset), 1);
        checkOutput("loss_n2_lock_lost", int'(lock_lost), CNT_EN ? 1 : 0);
        checkOutput("loss_n2_loss_count", int'(loss_count), CNT_EN ? 1 : 0);
        @(posedge clock_in); #1;
        checkOutput("loss_n3_lock_lost", int'(lock_lost), 0);

        // Re-lock requires the full sequence again
        applyStimulus(1'b1, 1'b0);
        runQualify("relock");

        // Many loss / re-lock cycles drive the count into saturation
        repeat (260) begin
            applyStimulus(1'b0, 1'b0);
            repeat (3) applyStimulus(1'b0, 1'b0);
            repeat (12) applyStimulus(1'b1, 1'b0);
        end
        #1;
        checkOutput("sat_loss_count", int'(loss_count), CNT_EN ? 255 : 0);
        checkOutput("sat_ready", int'(ready), 1);

        // Clear coincident with a loss: clear wins, pulse still fires
        applyStimulus(1'b0, 1'b0);
        @(posedge clock_in);
        @(posedge clock_in);
        #1;
        clear_count = 1'b1;
        @(posedge clock_in);
        #1;
        clear_count = 1'b0;
        checkOutput("clr_loss_lock_lost", int'(lock_lost), CNT_EN ? 1 : 0);
        checkOutput("clr_loss_loss_count", int'(loss_count), 0);

        // Asynchronous reset in the middle of HOLD
        applyStimulus(1'b1, 1'b0);
        repeat (2 + L + 2) @(posedge clock_in);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("hold_rst_sys_reset", int'(sys_reset), 1);
        checkOutput("hold_rst_ready", int'(ready), 0);
        checkOutput("hold_rst_loss_count", int'(loss_count), 0);
        @(negedge clock_in);
        reset = 1'b0;
        runQualify("after_hold_rst");

        // Build a nonzero count, then reset asynchronously in RUN
        applyStimulus(1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        runQualify("pre_run_rst");
        checkOutput("pre_run_rst_count", int'(loss_count), CNT_EN ? 1 : 0);
        @(negedge clock_in);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("run_rst_sys_reset", int'(sys_reset), 1);
        checkOutput("run_rst_ready", int'(ready), 0);
        checkOutput("run_rst_loss_count", int'(loss_count), 0);
        checkOutput("run_rst_lock_lost", int'(lock_lost), 0);
        @(negedge clock_in);
        reset = 1'b0;
        runQualify("after_run_rst");

        // Randomized lock chatter, clears and occasional async resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_in);
            if (reset) reset = 1'b0;
            if ($urandom_range(0, 19) == 0) locked = ~locked;
            clear_count = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
            end
        end
        @(negedge clock_in);
        reset = 1'b0;
        repeat (4) @(negedge clock_in);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
